// File: rtl/ppu_bg_fetcher.sv
// PPU background fetcher: runs the NT/AT/pattern-lo/pattern-hi read sequence
// against a 1-cycle-latency memory port and feeds 16-bit pixel shift registers.
module ppu_bg_fetcher #(
   parameter logic [13:0] NT_BASE = 14'h2000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic [14:0] v_addr,
   input  logic        bg_pt_sel,
   input  logic [2:0]  fine_x,
   input  logic        shift_en,
   output logic [13:0] mem_addr,
   output logic        mem_rw,
   input  logic [7:0]  mem_q,
   output logic        inc_x,
   output logic        tile_valid,
   output logic [3:0]  pix
);

   typedef enum logic [2:0] {
      PH_NT_ADDR,
      PH_NT_DATA,
      PH_AT_ADDR,
      PH_AT_DATA,
      PH_LO_ADDR,
      PH_LO_DATA,
      PH_HI_ADDR,
      PH_HI_DATA
   } phase_t;

   phase_t      phase;
   logic [7:0]  nt_byte;
   logic [1:0]  at_bits;
   logic [7:0]  pt_lo;
   logic [15:0] sh_lo;
   logic [15:0] sh_hi;
   logic [15:0] at_lo;
   logic [15:0] at_hi;
   logic [15:0] sh_lo_nx;
   logic [15:0] sh_hi_nx;
   logic [15:0] at_lo_nx;
   logic [15:0] at_hi_nx;
   logic        reload;
   logic [2:0]  at_shift;
   logic [7:0]  at_byte;
   logic [3:0]  tap;
   logic [13:0] nt_addr;
   logic [13:0] at_addr;
   logic [13:0] pt_lo_addr;
   logic [13:0] pt_hi_addr;

   assign mem_rw = 1'b0;
   assign reload = fetch_en && (phase == PH_HI_DATA);
   assign inc_x  = reload;

   // Address is combinational so it follows v_addr even while the phase is held.
   always_comb begin
      nt_addr    = NT_BASE | {2'b00, v_addr[11:0]};
      at_addr    = NT_BASE | 14'h03C0 |
                   {2'b00, v_addr[11:10], 4'b0000, v_addr[9:7], v_addr[4:2]};
      pt_lo_addr = {1'b0, bg_pt_sel, nt_byte, 1'b0, v_addr[14:12]};
      pt_hi_addr = pt_lo_addr | 14'h0008;
      case (phase)
         PH_NT_ADDR, PH_NT_DATA: mem_addr = nt_addr;
         PH_AT_ADDR, PH_AT_DATA: mem_addr = at_addr;
         PH_LO_ADDR, PH_LO_DATA: mem_addr = pt_lo_addr;
         PH_HI_ADDR, PH_HI_DATA: mem_addr = pt_hi_addr;
         default:                mem_addr = nt_addr;
      endcase
   end

   always_comb begin
      at_shift = {v_addr[6], v_addr[1], 1'b0};
      at_byte  = mem_q >> at_shift;
   end

   // Shift first, then the reload overwrites the low byte; pattern-high is
   // forwarded straight from mem_q so it never needs its own register.
   always_comb begin
      sh_lo_nx = sh_lo;
      sh_hi_nx = sh_hi;
      at_lo_nx = at_lo;
      at_hi_nx = at_hi;
      if (shift_en) begin
         sh_lo_nx = {sh_lo[14:0], 1'b0};
         sh_hi_nx = {sh_hi[14:0], 1'b0};
         at_lo_nx = {at_lo[14:0], 1'b0};
         at_hi_nx = {at_hi[14:0], 1'b0};
      end
      if (reload) begin
         sh_lo_nx[7:0] = pt_lo;
         sh_hi_nx[7:0] = mem_q;
         at_lo_nx[7:0] = {8{at_bits[0]}};
         at_hi_nx[7:0] = {8{at_bits[1]}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase      <= PH_NT_ADDR;
         nt_byte    <= '0;
         at_bits    <= '0;
         pt_lo      <= '0;
         sh_lo      <= '0;
         sh_hi      <= '0;
         at_lo      <= '0;
         at_hi      <= '0;
         tile_valid <= 1'b0;
      end else begin
         sh_lo      <= sh_lo_nx;
         sh_hi      <= sh_hi_nx;
         at_lo      <= at_lo_nx;
         at_hi      <= at_hi_nx;
         tile_valid <= reload;
         if (fetch_en) begin
            phase <= phase_t'(phase + 3'd1);
            case (phase)
               PH_NT_DATA: nt_byte <= mem_q;
               PH_AT_DATA: at_bits <= at_byte[1:0];
               PH_LO_DATA: pt_lo   <= mem_q;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      tap = 4'd15 - {1'b0, fine_x};
      pix = {at_hi[tap], at_lo[tap], sh_hi[tap], sh_lo[tap]};
   end

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// Bench for ppu_bg_fetcher: directed test-plan cases plus random traffic,
// checked against a pixel-array reference model and a 1-cycle-latency memory.
module tb_ppu_bg_fetcher;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic [14:0] v_addr;
   logic        bg_pt_sel;
   logic [2:0]  fine_x;
   logic        shift_en;
   logic [13:0] mem_addr;
   logic        mem_rw;
   logic [7:0]  mem_q;
   logic        inc_x;
   logic        tile_valid;
   logic [3:0]  pix;

   logic [7:0]  mem [0:16383];

   int n_checks = 0;
   int n_fail   = 0;

   int          m_ph;
   logic [7:0]  m_nt;
   logic [7:0]  m_lo;
   logic [7:0]  m_mq;
   logic [1:0]  m_at;
   logic        m_tv;
   logic [3:0]  m_px [0:15];

   int          tile1_addr [0:3] = '{'h2000, 'h23C0, 'h0240, 'h0248};
   logic [7:0]  nt2;
   logic [7:0]  lo2;
   logic [7:0]  hi2;
   logic [1:0]  at2;

   ppu_bg_fetcher #(.NT_BASE(14'h2000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_en   (fetch_en),
      .v_addr     (v_addr),
      .bg_pt_sel  (bg_pt_sel),
      .fine_x     (fine_x),
      .shift_en   (shift_en),
      .mem_addr   (mem_addr),
      .mem_rw     (mem_rw),
      .mem_q      (mem_q),
      .inc_x      (inc_x),
      .tile_valid (tile_valid),
      .pix        (pix)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory wrapper: data for the address presented shows up one cycle later.
   always @(posedge clk) mem_q <= mem[mem_addr];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_addr(input int ph, input logic [14:0] v, input logic pt,
                                   input logic [7:0] nt);
      int cx, cy, ns, fy;
      cx = int'(v[4:0]);
      cy = int'(v[9:5]);
      ns = int'(v[11:10]);
      fy = int'(v[14:12]);
      case (ph / 2)
         0:       return 'h2000 + int'(v[11:0]);
         1:       return 'h23C0 + ns * 'h400 + (cy / 4) * 8 + cx / 4;
         2:       return int'(pt) * 'h1000 + int'(nt) * 16 + fy;
         default: return int'(pt) * 'h1000 + int'(nt) * 16 + 8 + fy;
      endcase
   endfunction

   function automatic logic [1:0] at_of(input logic [7:0] b, input logic [14:0] v);
      int cx, cy, sh;
      cx = int'(v[4:0]);
      cy = int'(v[9:5]);
      sh = ((cy / 2) % 2) * 4 + ((cx / 2) % 2) * 2;
      return 2'((int'(b) >> sh) % 4);
   endfunction

   task automatic model_reset();
      m_ph = 0;
      m_nt = '0;
      m_lo = '0;
      m_at = '0;
      m_mq = '0;
      m_tv = 1'b0;
      for (int i = 0; i < 16; i++) m_px[i] = '0;
   endtask

   // Present inputs for this cycle and compare every output with the model.
   task automatic drive(input logic en, input logic sh, input logic [2:0] fx);
      fetch_en = en;
      shift_en = sh;
      fine_x   = fx;
      #1;
      check_eq("mem_addr", mem_addr, exp_addr(m_ph, v_addr, bg_pt_sel, m_nt));
      check_eq("inc_x", inc_x, en && (m_ph == 7));
      check_eq("tile_valid", tile_valid, m_tv);
      check_eq("pix", pix, m_px[fx]);
      check_eq("mem_rw", mem_rw, 0);
   endtask

   // Advance the model across the coming edge, take the edge, and act as the
   // owner of v_addr when a coarse-X increment was due.
   task automatic tick();
      int   a;
      logic rl;
      a  = exp_addr(m_ph, v_addr, bg_pt_sel, m_nt);
      rl = fetch_en && (m_ph == 7);
      if (shift_en) begin
         for (int i = 0; i < 15; i++) m_px[i] = m_px[i + 1];
         m_px[15] = '0;
      end
      if (rl) begin
         for (int k = 0; k < 8; k++) m_px[8 + k] = {m_at, m_mq[7 - k], m_lo[7 - k]};
      end
      if (fetch_en) begin
         case (m_ph)
            1: m_nt = m_mq;
            3: m_at = at_of(m_mq, v_addr);
            5: m_lo = m_mq;
            default: ;
         endcase
         m_ph = (m_ph + 1) % 8;
      end
      m_tv = rl;
      m_mq = mem[a];
      @(posedge clk);
      #1;
      if (rl) begin
         if (v_addr[4:0] == 5'd31) begin
            v_addr[4:0] = '0;
            v_addr[10]  = ~v_addr[10];
         end else begin
            v_addr[4:0] = v_addr[4:0] + 5'd1;
         end
      end
   endtask

   task automatic apply_reset();
      fetch_en = 1'b0;
      shift_en = 1'b0;
      rst_n    = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic shift_n(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b1, 3'd0);
         tick();
      end
   endtask

   task automatic observe(input logic [7:0] lo, input logic [7:0] hi, input logic [1:0] at);
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b1, 3'd0);
         check_eq("tile_pix", pix, {at, hi[7 - k], lo[7 - k]});
         tick();
      end
   endtask

   initial begin
      rst_n     = 1'b1;
      fetch_en  = 1'b0;
      shift_en  = 1'b0;
      fine_x    = '0;
      v_addr    = '0;
      bg_pt_sel = 1'b0;
      for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
      mem['h2000] = 8'h24;
      mem['h23C0] = 8'hE4;
      mem['h0240] = 8'hAA;
      mem['h0248] = 8'h55;
      model_reset();

      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 3'd0);
      check_eq("rst_addr", mem_addr, 'h2000);
      check_eq("rst_pix", pix, 0);
      tick();

      // Single tile at v=0
      v_addr = '0;
      bg_pt_sel = 1'b0;
      apply_reset();
      for (int p = 0; p < 8; p++) begin
         drive(1'b1, 1'b0, 3'd0);
         check_eq("t1_addr", mem_addr, tile1_addr[p / 2]);
         check_eq("t1_inc", inc_x, p == 7);
         tick();
      end
      drive(1'b0, 1'b0, 3'd0);
      check_eq("t1_valid", tile_valid, 1);
      tick();
      shift_n(8);
      observe(8'hAA, 8'h55, 2'b00);

      // Attribute quadrant selection
      v_addr = 15'h0042;
      apply_reset();
      for (int p = 0; p < 8; p++) begin
         drive(1'b1, 1'b0, 3'd0);
         if (p == 2) check_eq("at_addr_q", mem_addr, 'h23C0);
         tick();
      end
      drive(1'b0, 1'b0, 3'd0);
      tick();
      shift_n(8);
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b1, 3'd0);
         check_eq("at_pal", pix[3:2], 3);
         tick();
      end
      v_addr = 15'h0C00;
      apply_reset();
      for (int p = 0; p < 8; p++) begin
         drive(1'b1, 1'b0, 3'd0);
         if (p == 2) check_eq("at_addr_ns", mem_addr, 'h2FC0);
         tick();
      end

      // Pattern table select and fine Y
      mem['h2000] = 8'h7F;
      v_addr = 15'h5000;
      bg_pt_sel = 1'b1;
      apply_reset();
      for (int p = 0; p < 8; p++) begin
         drive(1'b1, 1'b0, 3'd0);
         if (p == 4) check_eq("pt_lo_addr", mem_addr, 'h17F5);
         if (p == 6) check_eq("pt_hi_addr", mem_addr, 'h17FD);
         tick();
      end
      mem['h2000] = 8'h24;
      bg_pt_sel = 1'b0;

      // fetch_en gap at phase 3, then fine_x tap
      v_addr = '0;
      apply_reset();
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 1'b0, 3'd0);
         tick();
      end
      for (int g = 0; g < 5; g++) begin
         drive(1'b0, 1'b0, 3'd0);
         check_eq("gap_addr", mem_addr, 'h23C0);
         check_eq("gap_inc", inc_x, 0);
         tick();
      end
      for (int p = 3; p < 8; p++) begin
         drive(1'b1, 1'b0, 3'd0);
         tick();
      end
      drive(1'b0, 1'b0, 3'd0);
      check_eq("gap_valid", tile_valid, 1);
      tick();
      shift_n(8);
      drive(1'b0, 1'b0, 3'd3);
      check_eq("fx3_pix", pix[1:0], 2'b10);
      tick();
      observe(8'hAA, 8'h55, 2'b00);

      // Shift and reload on the same edge
      v_addr = '0;
      apply_reset();
      for (int p = 0; p < 8; p++) begin
         drive(1'b1, 1'b0, 3'd0);
         tick();
      end
      for (int p = 0; p < 8; p++) begin
         drive(1'b1, 1'b1, 3'd0);
         tick();
      end
      drive(1'b0, 1'b0, 3'd0);
      check_eq("sr_valid", tile_valid, 1);
      check_eq("sr_upper0", pix, 1);
      drive(1'b0, 1'b0, 3'd7);
      check_eq("sr_upper7", pix, 2);
      tick();
      nt2 = mem['h2001];
      lo2 = mem[int'(nt2) * 16];
      hi2 = mem[int'(nt2) * 16 + 8];
      at2 = at_of(mem['h23C0], 15'h0001);
      shift_n(8);
      observe(lo2, hi2, at2);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 31) == 0) v_addr = 15'($urandom);
         if ($urandom_range(0, 63) == 0) bg_pt_sel = ~bg_pt_sel;
         drive($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
         tick();
      end

      // Asynchronous reset in the middle of phase 5
      for (int i = 0; i < 8 && m_ph != 5; i++) begin
         drive(1'b1, 1'b1, 3'd0);
         tick();
      end
      v_addr = 15'h0123;
      drive(1'b1, 1'b1, 3'd0);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_pix", pix, 0);
      check_eq("mid_rst_inc", inc_x, 0);
      check_eq("mid_rst_valid", tile_valid, 0);
      check_eq("mid_rst_addr", mem_addr, 'h2123);
      apply_reset();
      drive(1'b1, 1'b0, 3'd0);
      check_eq("post_rst_addr", mem_addr, 'h2123);
      tick();
      for (int p = 1; p < 8; p++) begin
         drive(1'b1, 1'b0, 3'd0);
         tick();
      end
      drive(1'b0, 1'b0, 3'd0);
      check_eq("post_rst_valid", tile_valid, 1);
      tick();
      shift_n(16);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
